// File: rtl/ad9959_spi_lite_slave_if.sv
// AXI4-Lite channel bundle for the AD9959 command block; slave modport faces
// the register file, master modport faces the interconnect or a bench.
interface ad9959_spi_lite_slave_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]                      S_AXI_AWPROT;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]                      S_AXI_ARPROT;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/ad9959_spi_lite_slave.sv
// AXI4-Lite register front end that turns each software command into one
// AD9959 3-wire serial transaction with an optional IO_UPDATE pulse.
module ad9959_spi_lite_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int CLK_DIV            = 4,
    parameter int IOUP_CYCLES        = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    ad9959_spi_lite_slave_if.slave        s_axi,
    output logic                          dds_cs_n,
    output logic                          dds_sclk,
    output logic                          dds_sdio_o,
    output logic                          dds_sdio_t,
    input  logic                          dds_sdio_i,
    output logic                          dds_io_update
);
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_SHIFT, ST_STOP, ST_IOUP} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV);
    localparam logic [15:0] IOUP_LAST = 16'(IOUP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [7:0]  instr_q, instr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdreg_q, rdreg_d;
    logic        done_q, done_d;
    logic        awready_q, awready_d, bvalid_q, bvalid_d;
    logic        arready_q, arready_d, rvalid_q, rvalid_d;
    logic [31:0] axi_rdata_q, axi_rdata_d;
    logic [39:0] shift_q, shift_d;
    logic [5:0]  bits_q, bits_d, bit_cnt_q, bit_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d, io_cnt_q, io_cnt_d;
    logic        phase_q, phase_d, is_read_q, is_read_d, ioup_en_q, ioup_en_d;
    logic [31:0] rx_q, rx_d;
    logic        cs_n_q, cs_n_d, sclk_q, sclk_d, sdio_o_q, sdio_o_d;
    logic        sdio_t_q, sdio_t_d, io_update_q, io_update_d;
    logic        wr_hs, rd_hs, start;

    assign wr_hs = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_hs = arready_q & s_axi.S_AXI_ARVALID;

    always_comb begin
        state_d     = state_q;     ctrl_d      = ctrl_q;      instr_d   = instr_q;
        wdata_d     = wdata_q;     rdreg_d     = rdreg_q;     done_d    = done_q;
        awready_d   = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d    = bvalid_q & ~s_axi.S_AXI_BREADY;
        arready_d   = s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d    = rvalid_q & ~s_axi.S_AXI_RREADY;
        axi_rdata_d = axi_rdata_q;
        shift_d     = shift_q;     bits_d      = bits_q;      bit_cnt_d = bit_cnt_q;
        div_cnt_d   = div_cnt_q;   io_cnt_d    = io_cnt_q;    phase_d   = phase_q;
        is_read_d   = is_read_q;   ioup_en_d   = ioup_en_q;   rx_d      = rx_q;
        cs_n_d      = cs_n_q;      sclk_d      = sclk_q;      sdio_o_d  = sdio_o_q;
        sdio_t_d    = sdio_t_q;    io_update_d = io_update_q;
        start       = 1'b0;

        if (wr_hs) begin
            bvalid_d = 1'b1;
            case (s_axi.S_AXI_AWADDR[4:2])
                3'd0: if (s_axi.S_AXI_WSTRB[0]) ctrl_d = s_axi.S_AXI_WDATA[2:0];
                3'd1: if (s_axi.S_AXI_WSTRB[0]) instr_d = s_axi.S_AXI_WDATA[7:0];
                3'd2: for (int unsigned i = 0; i < 4; i++)
                          if (s_axi.S_AXI_WSTRB[i]) wdata_d[8*i +: 8] = s_axi.S_AXI_WDATA[8*i +: 8];
                3'd3: if (s_axi.S_AXI_WSTRB[0]) begin
                          if (s_axi.S_AXI_WDATA[1]) done_d = 1'b0;
                          start = s_axi.S_AXI_WDATA[0] && (state_q == ST_IDLE);
                      end
                default: ;
            endcase
        end

        if (rd_hs) begin
            rvalid_d = 1'b1;
            case (s_axi.S_AXI_ARADDR[4:2])
                3'd0:    axi_rdata_d = {29'd0, ctrl_q};
                3'd1:    axi_rdata_d = {24'd0, instr_q};
                3'd2:    axi_rdata_d = wdata_q;
                3'd3:    axi_rdata_d = {30'd0, done_q, state_q != ST_IDLE};
                3'd4:    axi_rdata_d = rdreg_q;
                default: axi_rdata_d = '0;
            endcase
        end

        case (state_q)
            ST_IDLE: if (start) begin
                // Data bytes are left-aligned under the instruction so the shifter always emits from bit 39.
                shift_d   = {instr_q, wdata_q << {~ctrl_q[1:0], 3'b000}};
                bits_d    = {3'(ctrl_q[1:0]) + 3'd2, 3'b000};
                bit_cnt_d = '0;   div_cnt_d = '0;   phase_d = 1'b0;   rx_d = '0;
                is_read_d = instr_q[7];   ioup_en_d = ctrl_q[2];
                state_d   = ST_START;
                cs_n_d    = 1'b0; sclk_d = 1'b0; sdio_t_d = 1'b0; sdio_o_d = instr_q[7];
            end
            ST_START: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (!phase_q) begin
                    if (div_cnt_q == DIV_LAST) begin
                        phase_d = 1'b1; sclk_d = 1'b1; div_cnt_d = '0;
                    end else div_cnt_d = div_cnt_q + 16'd1;
                end else begin
                    if (div_cnt_q == '0 && is_read_q && bit_cnt_q >= 6'd8)
                        rx_d = {rx_q[30:0], dds_sdio_i};
                    if (div_cnt_q == DIV_LAST) begin
                        div_cnt_d = '0; phase_d = 1'b0; sclk_d = 1'b0;
                        if (bit_cnt_q == bits_q - 6'd1) begin
                            state_d = ST_STOP; cs_n_d = 1'b1; sdio_o_d = 1'b0; sdio_t_d = 1'b0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            shift_d   = {shift_q[38:0], 1'b0};
                            sdio_o_d  = shift_q[38];
                            if (is_read_q && bit_cnt_q == 6'd7) sdio_t_d = 1'b1;
                        end
                    end else div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (is_read_q) rdreg_d = rx_q;
                if (ioup_en_q) begin
                    state_d = ST_IOUP; io_update_d = 1'b1; io_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE; done_d = 1'b1;
                end
            end
            ST_IOUP: begin
                if (io_cnt_q == IOUP_LAST) begin
                    state_d = ST_IDLE; io_update_d = 1'b0; done_d = 1'b1;
                end else io_cnt_d = io_cnt_q + 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= ST_IDLE; ctrl_q   <= '0; instr_q <= '0; wdata_q <= '0;
            rdreg_q   <= '0;      done_q   <= 1'b0;
            awready_q <= 1'b0;    bvalid_q <= 1'b0; arready_q <= 1'b0; rvalid_q <= 1'b0;
            axi_rdata_q <= '0;
            shift_q   <= '0; bits_q <= '0; bit_cnt_q <= '0; div_cnt_q <= '0; io_cnt_q <= '0;
            phase_q   <= 1'b0; is_read_q <= 1'b0; ioup_en_q <= 1'b0; rx_q <= '0;
            cs_n_q    <= 1'b1; sclk_q <= 1'b0; sdio_o_q <= 1'b0; sdio_t_q <= 1'b0;
            io_update_q <= 1'b0;
        end else begin
            state_q   <= state_d; ctrl_q   <= ctrl_d; instr_q <= instr_d; wdata_q <= wdata_d;
            rdreg_q   <= rdreg_d; done_q   <= done_d;
            awready_q <= awready_d; bvalid_q <= bvalid_d; arready_q <= arready_d; rvalid_q <= rvalid_d;
            axi_rdata_q <= axi_rdata_d;
            shift_q   <= shift_d; bits_q <= bits_d; bit_cnt_q <= bit_cnt_d; div_cnt_q <= div_cnt_d;
            io_cnt_q  <= io_cnt_d;
            phase_q   <= phase_d; is_read_q <= is_read_d; ioup_en_q <= ioup_en_d; rx_q <= rx_d;
            cs_n_q    <= cs_n_d; sclk_q <= sclk_d; sdio_o_q <= sdio_o_d; sdio_t_q <= sdio_t_d;
            io_update_q <= io_update_d;
        end
    end

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = awready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RDATA   = axi_rdata_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;

    assign dds_cs_n      = cs_n_q;
    assign dds_sclk      = sclk_q;
    assign dds_sdio_o    = sdio_o_q;
    assign dds_sdio_t    = sdio_t_q;
    assign dds_io_update = io_update_q;

    logic unused_ok;
    assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR[1:0],
                         s_axi.S_AXI_ARADDR[1:0], shift_q[39]};
endmodule

// File: tb/tb_ad9959_spi_lite_slave.sv
// Directed bench for ad9959_spi_lite_slave: register access, write/read
// serial transactions, IO_UPDATE timing, busy-start rejection and mid-transfer reset.
module tb_ad9959_spi_lite_slave;
    logic clk, rst;
    logic dds_cs_n, dds_sclk, dds_sdio_o, dds_sdio_t, dds_sdio_i, dds_io_update;

    ad9959_spi_lite_slave_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

    ad9959_spi_lite_slave #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .CLK_DIV(4), .IOUP_CYCLES(8)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .s_axi(bus.slave),
        .dds_cs_n(dds_cs_n), .dds_sclk(dds_sclk), .dds_sdio_o(dds_sdio_o),
        .dds_sdio_t(dds_sdio_t), .dds_sdio_i(dds_sdio_i), .dds_io_update(dds_io_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pin monitor: SCLK-rise captures of SDIO drive/tristate plus per-cycle counters.
    int          mon_rise, mon_cs_low, mon_t_cyc, mon_ioup, mon_txn, cyc;
    int          cs_rise_cyc, iou_rise_cyc;
    logic        cs_prev = 1'b1, iou_prev = 1'b0;
    logic [63:0] mon_bits, mon_tbits;

    always @(posedge dds_sclk) begin
        mon_rise++;
        mon_bits  = {mon_bits[62:0], dds_sdio_o};
        mon_tbits = {mon_tbits[62:0], dds_sdio_t};
    end

    always @(posedge clk) begin
        cyc++;
        if (!dds_cs_n) mon_cs_low++;
        if (dds_sdio_t) mon_t_cyc++;
        if (dds_io_update) mon_ioup++;
        if (!dds_cs_n && cs_prev) mon_txn++;
        if (dds_cs_n && !cs_prev) cs_rise_cyc = cyc;
        if (dds_io_update && !iou_prev) iou_rise_cyc = cyc;
        cs_prev  = dds_cs_n;
        iou_prev = dds_io_update;
    end

    task automatic clear_mon();
        mon_rise = 0; mon_cs_low = 0; mon_t_cyc = 0; mon_ioup = 0; mon_txn = 0;
        mon_bits = '0; mon_tbits = '0; cs_rise_cyc = -1; iou_rise_cyc = -1;
    endtask

    // AD9959 SDIO model: drives pat MSB first, changing after each SCLK fall from bit 8 on.
    int         fall_cnt;
    logic [7:0] pat;
    always @(negedge dds_cs_n) fall_cnt = 0;
    always @(negedge dds_sclk) fall_cnt++;
    always_comb dds_sdio_i = (fall_cnt >= 8 && fall_cnt < 16) ? pat[15 - fall_cnt] : 1'b0;

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int unsigned t;
        @(posedge clk); #1;
        bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_AWREADY && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check("awready_timeout", 64'(bus.S_AXI_AWREADY), 64'd1);
        @(posedge clk); #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b1;
        t = 0;
        while (!bus.S_AXI_BVALID && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check("bvalid_timeout", 64'(bus.S_AXI_BVALID), 64'd1);
        check("bresp", 64'(bus.S_AXI_BRESP), 64'd0);
        @(posedge clk); #1;
        bus.S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int unsigned t;
        @(posedge clk); #1;
        bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1;
        t = 0;
        while (!bus.S_AXI_ARREADY && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check("arready_timeout", 64'(bus.S_AXI_ARREADY), 64'd1);
        @(posedge clk); #1;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b1;
        t = 0;
        while (!bus.S_AXI_RVALID && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) check("rvalid_timeout", 64'(bus.S_AXI_RVALID), 64'd1);
        d = bus.S_AXI_RDATA;
        if (bus.S_AXI_RRESP !== 2'b00) check("rresp", 64'(bus.S_AXI_RRESP), 64'd0);
        @(posedge clk); #1;
        bus.S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        int unsigned n;
        n = 0;
        do begin axi_read(5'h0C, d); n++; end while (d[0] && n < 500);
        if (d[0]) check("idle_timeout", 64'(d), 64'h2);
    endtask

    initial begin
        logic [31:0] rd;
        int unsigned t;
        rst = 1'b1; pat = 8'hA5;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
        clear_mon();

        // Reset state
        repeat (5) @(posedge clk); #1;
        check("rst_cs_n", 64'(dds_cs_n), 64'd1);
        check("rst_sclk", 64'(dds_sclk), 64'd0);
        check("rst_sdio_o", 64'(dds_sdio_o), 64'd0);
        check("rst_sdio_t", 64'(dds_sdio_t), 64'd0);
        check("rst_io_update", 64'(dds_io_update), 64'd0);
        check("rst_axi_flags", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                                     bus.S_AXI_ARREADY, bus.S_AXI_RVALID}), 64'd0);
        check("rst_rdata_bus", 64'(bus.S_AXI_RDATA), 64'd0);
        repeat (15) @(posedge clk); #1;
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            axi_read(5'(a * 4), rd);
            check($sformatf("rst_reg_%0h", a * 4), 64'(rd), 64'd0);
        end

        // Register readback, byte strobes, unmapped space
        axi_write(5'h00, 32'd1, 4'hF);
        axi_write(5'h04, 32'd2, 4'hF);
        axi_write(5'h08, 32'd3, 4'hF);
        axi_read(5'h00, rd); check("ctrl_rb", 64'(rd), 64'd1);
        axi_read(5'h04, rd); check("instr_rb", 64'(rd), 64'd2);
        axi_read(5'h08, rd); check("wdata_rb", 64'(rd), 64'd3);
        axi_write(5'h08, 32'hAABBCCDD, 4'b0101);
        axi_read(5'h08, rd); check("wdata_strb", 64'(rd), 64'h00BB00DD);
        axi_write(5'h00, 32'hFFFF_FFFF, 4'hF);
        axi_read(5'h00, rd); check("ctrl_mask", 64'(rd), 64'd7);
        axi_write(5'h04, 32'h0000_1234, 4'b0010);
        axi_read(5'h04, rd); check("instr_lane1_ignored", 64'(rd), 64'd2);
        axi_write(5'h14, 32'hFF, 4'hF);
        axi_read(5'h14, rd); check("unmapped_0x14", 64'(rd), 64'd0);

        // Write transaction, 3 data bytes
        axi_write(5'h00, 32'd2, 4'hF);
        axi_write(5'h04, 32'h04, 4'hF);
        axi_write(5'h08, 32'h00123456, 4'hF);
        clear_mon();
        axi_write(5'h0C, 32'd1, 4'hF);
        axi_read(5'h0C, rd); check("wr_busy", 64'(rd), 64'h1);
        wait_idle();
        axi_read(5'h0C, rd); check("wr_done", 64'(rd), 64'h2);
        check("wr_rises", 64'(mon_rise), 64'd32);
        check("wr_bits", 64'(mon_bits[31:0]), 64'h04123456);
        check("wr_cs_low", 64'(mon_cs_low), 64'd321);
        check("wr_sdio_t", 64'(mon_t_cyc), 64'd0);
        check("wr_ioup", 64'(mon_ioup), 64'd0);

        // Read transaction, 1 data byte; clear-then-start in one write
        axi_write(5'h00, 32'd0, 4'hF);
        axi_write(5'h04, 32'h85, 4'hF);
        clear_mon();
        axi_write(5'h0C, 32'd3, 4'hF);
        axi_read(5'h0C, rd); check("rd_busy_done_cleared", 64'(rd), 64'h1);
        wait_idle();
        check("rd_rises", 64'(mon_rise), 64'd16);
        check("rd_instr_bits", 64'(mon_bits[15:8]), 64'h85);
        check("rd_t_at_rises", 64'(mon_tbits[15:0]), 64'h00FF);
        check("rd_t_cycles", 64'(mon_t_cyc), 64'd80);
        check("rd_cs_low", 64'(mon_cs_low), 64'd161);
        axi_read(5'h10, rd); check("rd_rdata", 64'(rd), 64'hA5);
        axi_read(5'h0C, rd); check("rd_done", 64'(rd), 64'h2);

        // IO_UPDATE and start-while-busy rejection
        axi_write(5'h00, 32'd4, 4'hF);
        axi_write(5'h04, 32'h12, 4'hF);
        axi_write(5'h08, 32'h34, 4'hF);
        clear_mon();
        axi_write(5'h0C, 32'd3, 4'hF);
        axi_write(5'h0C, 32'd1, 4'hF);
        wait_idle();
        check("iu_txn_count", 64'(mon_txn), 64'd1);
        check("iu_rises", 64'(mon_rise), 64'd16);
        check("iu_bits", 64'(mon_bits[15:0]), 64'h1234);
        check("iu_cs_low", 64'(mon_cs_low), 64'd161);
        check("iu_width", 64'(mon_ioup), 64'd8);
        check("iu_delay", 64'(iou_rise_cyc - cs_rise_cyc), 64'd1);
        axi_read(5'h10, rd); check("iu_rdata_kept", 64'(rd), 64'hA5);
        axi_read(5'h0C, rd); check("iu_done", 64'(rd), 64'h2);

        // Reset during bit 10, then a normal transaction
        axi_write(5'h00, 32'd6, 4'hF);
        axi_write(5'h04, 32'h04, 4'hF);
        axi_write(5'h08, 32'h00123456, 4'hF);
        clear_mon();
        axi_write(5'h0C, 32'd3, 4'hF);
        t = 0;
        while (mon_rise < 10 && t < 2000) begin @(posedge clk); t++; end
        if (mon_rise < 10) check("mid_wait_timeout", 64'(mon_rise), 64'd10);
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        #1;
        check("mid_cs_n", 64'(dds_cs_n), 64'd1);
        check("mid_sclk", 64'(dds_sclk), 64'd0);
        repeat (20) @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk); #1;
        check("mid_no_ioup", 64'(mon_ioup), 64'd0);
        axi_read(5'h0C, rd); check("mid_status", 64'(rd), 64'h0);
        axi_write(5'h00, 32'd0, 4'hF);
        axi_write(5'h04, 32'h21, 4'hF);
        axi_write(5'h08, 32'h5A, 4'hF);
        clear_mon();
        axi_write(5'h0C, 32'd1, 4'hF);
        wait_idle();
        check("post_rises", 64'(mon_rise), 64'd16);
        check("post_bits", 64'(mon_bits[15:0]), 64'h215A);
        check("post_cs_low", 64'(mon_cs_low), 64'd161);
        axi_read(5'h0C, rd); check("post_done", 64'(rd), 64'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule

// File: doc/ad9959_spi_lite_slave.md
# ad9959_spi_lite_slave

- AXI4-Lite responder that exposes a five-register command interface to software.
- Turns each software command into one AD9959 serial-port transaction: 3-wire, single-bit SDIO_0, MSB first. The transaction is an instruction byte plus 1–4 data bytes, with an optional IO_UPDATE pulse afterwards.
- Sits between the processor's AXI4-Lite interconnect and the AD9959 pins. It is the slave end of the AXI4-Lite master sequences the team's benches already issue.

## Interface

**Parameters**
- C_S_AXI_DATA_WIDTH, 32 — AXI data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 5 — byte address width; decodes ADDR[4:2].
- CLK_DIV, 4 — each SCLK half-period lasts CLK_DIV+1 ACLK cycles.
- IOUP_CYCLES, 8 — IO_UPDATE pulse width in ACLK cycles; must be ≥1.

**Ports**
- S_AXI_ACLK, in, 1 — single clock.
- S_AXI_ARESET, in, 1 — reset, asynchronous, active-high.
- S_AXI_AWADDR, in, 5; S_AXI_AWPROT, in, 3 (ignored); S_AXI_AWVALID, in, 1; S_AXI_AWREADY, out, 1.
- S_AXI_WDATA, in, 32; S_AXI_WSTRB, in, 4; S_AXI_WVALID, in, 1; S_AXI_WREADY, out, 1.
- S_AXI_BRESP, out, 2; S_AXI_BVALID, out, 1; S_AXI_BREADY, in, 1.
- S_AXI_ARADDR, in, 5; S_AXI_ARPROT, in, 3 (ignored); S_AXI_ARVALID, in, 1; S_AXI_ARREADY, out, 1.
- S_AXI_RDATA, out, 32; S_AXI_RRESP, out, 2; S_AXI_RVALID, out, 1; S_AXI_RREADY, in, 1.
- dds_cs_n, out, 1 — chip select, active low.
- dds_sclk, out, 1 — serial clock; idles low.
- dds_sdio_o, out, 1 — SDIO drive value.
- dds_sdio_t, out, 1 — SDIO tristate; 1 = released/input.
- dds_sdio_i, in, 1 — SDIO sampled value.
- dds_io_update, out, 1 — IO_UPDATE pulse, active high.

## Operation

**Register map** (each WSTRB byte lane gates its byte on writes):
- 0x00 CTRL, RW: [1:0] NB (data bytes − 1); [2] IOUP_EN; other bits read 0.
- 0x04 INSTR, RW: [7:0] instruction byte; bit 7 = 1 selects a read; other bits read 0.
- 0x08 WDATA, RW: data bytes are WDATA[8·(NB+1)−1:0], sent MSB first.
- 0x0C CMD/STATUS:
  - Write: bit 0 = 1 starts a transaction; bit 1 = 1 clears DONE.
  - Read: [0] BUSY; [1] DONE (sticky, set on return to IDLE).
- 0x10 RDATA, RO: captured read bytes, right-justified, zero-extended.
- Addresses 0x14–0x1C: writes are ignored, reads return 0, response is OKAY.

**Start rules**
- A start while BUSY = 1 is ignored; no state changes and the response is OKAY.
- A start and a DONE clear in the same write: clear takes effect first, then the transaction starts.

**FSM states**
- IDLE: dds_cs_n = 1, dds_sclk = 0, dds_sdio_t = 0. On start, latch INSTR, WDATA and CTRL into the shifter, compute bits = 8·(NB+2), go to START.
- START: one cycle. dds_cs_n = 0, dds_sdio_o = first bit. Go to SHIFT.
- SHIFT: each bit is a low half then a high half, each CLK_DIV+1 cycles.
  - The output bit changes only at the start of the low half.
  - dds_sdio_i is sampled on the cycle SCLK rises.
  - After the last high half, go to STOP.
- Read transactions: after the 8th bit's high half, dds_sdio_t = 1 for the remaining bits, and the sampled bits shift into RDATA.
- STOP: one cycle. dds_cs_n = 1, dds_sclk = 0, dds_sdio_t = 0. Go to IOUP if IOUP_EN, else IDLE.
- IOUP: dds_io_update = 1 for IOUP_CYCLES cycles, then go to IDLE.
- Entering IDLE sets DONE. RDATA updates only on read transactions, at STOP.

## Timing

**Reset values** (all outputs, while S_AXI_ARESET is high):
- All READY/VALID outputs 0; BRESP = RRESP = 00; RDATA = 0.
- dds_cs_n = 1; dds_sclk = 0; dds_sdio_o = 0; dds_sdio_t = 0; dds_io_update = 0.
- All registers 0; FSM in IDLE.
- Reset mid-transaction aborts immediately to these values; no IO_UPDATE is issued.

**AXI write**
- AWREADY and WREADY pulse together for one cycle when AWVALID & WVALID & !BVALID.
- BVALID rises the next cycle and holds until BREADY.
- Register update and start detection happen on the handshake cycle. BUSY reads 1 from the following cycle.

**AXI read**
- ARREADY pulses for one cycle when ARVALID & !RVALID.
- RVALID rises the next cycle and holds until RREADY; RDATA is stable while RVALID is high.

**Serial timing**
- dds_cs_n is low for exactly 1 + bits·2·(CLK_DIV+1) cycles.
- Total BUSY time = that + 1 (STOP) + (IOUP_EN ? IOUP_CYCLES : 0).
- All serial outputs are registered; no combinational path from AXI to the pins.

## Test plan

- **Reset.** Hold reset 20 cycles, release. Check all outputs at reset values; reads of 0x00–0x10 return 0.
- **Readback.** Write 0x00 = 1, 0x04 = 2, 0x08 = 3, read back.
  - Expect 1, 2, 3, BRESP/RRESP = OKAY.
  - Write 0x14 = 0xFF, then read 0x14: expect 0.
- **Write transaction.** Setup: CTRL = 2, INSTR = 0x04, WDATA = 0x00123456, CMD = 1, CLK_DIV = 4.
  - Expect 32 SCLK rises and SDIO bits 0x04123456 MSB first.
  - Expect dds_cs_n low 321 cycles, dds_sdio_t = 0 throughout, no IO_UPDATE, then DONE = 1.
- **Read transaction.** Setup: CTRL = 0, INSTR = 0x85; SDIO model drives 0xA5.
  - Expect dds_sdio_t = 1 during the last 8 bits only.
  - Expect RDATA = 0x000000A5 and DONE = 1.
- **IO_UPDATE and busy start.** Setup: CTRL = 4; issue CMD = 1, then CMD = 1 again while BUSY.
  - Expect exactly one transaction.
  - Expect dds_io_update high for 8 cycles, starting the cycle after dds_cs_n rises.
- **Reset mid-transaction.** Assert reset during bit 10.
  - Expect dds_cs_n = 1 and dds_sclk = 0 within the assertion, with no IO_UPDATE.
  - A following transaction completes normally.
